// File: rtl/adder_arb.sv
// rtl/adder_arb.sv - round-robin arbiter sharing one adder among NREQ requesters
//
// Grants one requester at a time, drives the adder operands and IEA/IEB
// handshake on its behalf, captures Y when OE rises, waits for OE to fall,
// then pulses DONE to the granted requester with the captured sum on RES.
//
// Optional feature: define ARB_TIMEOUT_EN to abort ISSUE/DRAIN after TIMEOUT
// cycles, setting the sticky ERR flag. Without it ERR is tied to 0.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   REQ             level request per requester, held until its DONE
//   REQ_A, REQ_B    packed operands, slice i belongs to requester i
//   GNT             registered one-hot grant
//   DONE            one-cycle completion pulse to the granted requester
//   RES             captured sum, held until the next capture
//   BUSY            high whenever the FSM is not IDLE
//   ERR             sticky timeout flag
//   AD_A, AD_B      operands to the adder
//   AD_IEA, AD_IEB  input enables to the adder
//   AD_Y, AD_OE     sum and output-valid from the adder
module adder_arb #(
  parameter int BITS    = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*BITS-1:0] REQ_A,
  input  logic [NREQ*BITS-1:0] REQ_B,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      DONE,
  output logic [BITS-1:0]      RES,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [BITS-1:0]      AD_A,
  output logic [BITS-1:0]      AD_B,
  output logic                 AD_IEA,
  output logic                 AD_IEB,
  input  logic [BITS-1:0]      AD_Y,
  input  logic                 AD_OE
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    CAPTURE,
    DRAIN,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [BITS-1:0]   res_q, res_d;
  logic              busy_q, busy_d;
  logic [BITS-1:0]   ad_a_q, ad_a_d;
  logic [BITS-1:0]   ad_b_q, ad_b_d;
  logic              ad_ie_q, ad_ie_d;
  logic [PW-1:0]     ptr_q, ptr_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Requester index at a cyclic offset from the round-robin pointer.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin pick: first set REQ strictly after the pointer, wrapping.
  logic            arb_found;
  logic [PW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_oh;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!arb_found && REQ[wrap_idx(ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(ptr_q, i);
      end
    end
    arb_oh = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    res_d   = res_q;
    ad_a_d  = ad_a_q;
    ad_b_d  = ad_b_q;
    ad_ie_d = ad_ie_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        ad_ie_d = 1'b0;
        if (arb_found) begin
          gnt_d   = arb_oh;
          ad_a_d  = REQ_A[int'(arb_idx)*BITS +: BITS];
          ad_b_d  = REQ_B[int'(arb_idx)*BITS +: BITS];
          ptr_d   = arb_idx;
          state_d = SETUP;
        end
      end

      // Operands have been stable for a full cycle; enables rise on ISSUE entry.
      SETUP: begin
        ad_ie_d = 1'b1;
        state_d = ISSUE;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      // An OE already high on entry is accepted as completion.
      ISSUE: begin
        if (AD_OE) begin
          res_d   = AD_Y;
          ad_ie_d = 1'b0;
          state_d = CAPTURE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ad_ie_d = 1'b0;
          done_d  = gnt_q;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      CAPTURE: begin
        ad_ie_d = 1'b0;
        state_d = DRAIN;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      DRAIN: begin
        if (!AD_OE) begin
          done_d  = gnt_q;
          state_d = FIN;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      FIN: begin
        gnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        ad_ie_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      ad_a_q  <= '0;
      ad_b_q  <= '0;
      ad_ie_q <= 1'b0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      ad_a_q  <= ad_a_d;
      ad_b_q  <= ad_b_d;
      ad_ie_q <= ad_ie_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign RES    = res_q;
  assign BUSY   = busy_q;
  assign AD_A   = ad_a_q;
  assign AD_B   = ad_b_q;
  assign AD_IEA = ad_ie_q;
  assign AD_IEB = ad_ie_q;

endmodule

// File: tb/tb_adder_arb.sv
// tb/tb_adder_arb.sv - directed self-checking bench for adder_arb
module tb_adder_arb;

  localparam int BITS = 8;
  localparam int NREQ = 4;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NREQ-1:0]      REQ;
  logic [NREQ*BITS-1:0] REQ_A;
  logic [NREQ*BITS-1:0] REQ_B;
  logic [NREQ-1:0]      GNT;
  logic [NREQ-1:0]      DONE;
  logic [BITS-1:0]      RES;
  logic                 BUSY;
  logic                 ERR;
  logic [BITS-1:0]      AD_A;
  logic [BITS-1:0]      AD_B;
  logic                 AD_IEA;
  logic                 AD_IEB;
  logic [BITS-1:0]      AD_Y;
  logic                 AD_OE;

  int checks = 0;
  int errors = 0;

  // Behavioural adder: OE rises oe_lat cycles after both enables are high,
  // falls fall_lat cycles after they drop; dead suppresses OE entirely.
  int oe_lat   = 1;
  int fall_lat = 1;
  bit dead     = 1'b0;
  int hi_cnt   = 0;
  int lo_cnt   = 0;

  adder_arb #(
    .BITS(BITS),
    .NREQ(NREQ),
    .TIMEOUT(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ(REQ),
    .REQ_A(REQ_A),
    .REQ_B(REQ_B),
    .GNT(GNT),
    .DONE(DONE),
    .RES(RES),
    .BUSY(BUSY),
    .ERR(ERR),
    .AD_A(AD_A),
    .AD_B(AD_B),
    .AD_IEA(AD_IEA),
    .AD_IEB(AD_IEB),
    .AD_Y(AD_Y),
    .AD_OE(AD_OE)
  );

  always #5 CLK = ~CLK;

  initial begin
    AD_OE = 1'b0;
    AD_Y  = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        AD_OE  = 1'b0;
        hi_cnt = 0;
        lo_cnt = 0;
      end else if (AD_IEA && AD_IEB) begin
        lo_cnt = 0;
        hi_cnt++;
        if (!dead && hi_cnt >= oe_lat) begin
          AD_OE = 1'b1;
          AD_Y  = AD_A + AD_B;
        end
      end else begin
        hi_cnt = 0;
        if (AD_OE) begin
          lo_cnt++;
          if (lo_cnt >= fall_lat) begin
            AD_OE  = 1'b0;
            lo_cnt = 0;
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    REQ_A[i*BITS +: BITS] = a;
    REQ_B[i*BITS +: BITS] = b;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (DONE != '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (GNT != '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_ie(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (AD_IEA) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    RST   = 1'b1;
    REQ   = '0;
    REQ_A = '0;
    REQ_B = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({GNT, DONE, BUSY, ERR} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b busy=%b err=%b expected all 0", GNT, DONE, BUSY, ERR);
    end
    checks++;
    if ({RES, AD_A, AD_B, AD_IEA, AD_IEB} !== '0) begin
      errors++;
      $display("FAIL reset_data: got res=%0d a=%0d b=%0d iea=%b ieb=%b expected all 0", RES, AD_A, AD_B, AD_IEA, AD_IEB);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single;
    bit ok;
    set_op(0, 8'd3, 8'd4);
    REQ = 4'b0001;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0001 || BUSY !== 1'b1 || AD_A !== 8'd3 || AD_B !== 8'd4 || AD_IEA !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b busy=%b a=%0d b=%0d iea=%b expected 0001 1 3 4 0", GNT, BUSY, AD_A, AD_B, AD_IEA);
    end
    @(negedge CLK);
    checks++;
    if (AD_IEA !== 1'b1 || AD_IEB !== 1'b1) begin
      errors++;
      $display("FAIL single_ie_rise: got iea=%b ieb=%b expected 1 1", AD_IEA, AD_IEB);
    end
    wait_done(ok);
    checks++;
    if (!ok || DONE !== 4'b0001 || RES !== 8'd7) begin
      errors++;
      $display("FAIL single_done: got seen=%b done=%b res=%0d expected 1 0001 7", ok, DONE, RES);
    end
    REQ = '0;
    @(negedge CLK);
    checks++;
    if (DONE !== 4'b0000 || BUSY !== 1'b0 || GNT !== 4'b0000 || RES !== 8'd7) begin
      errors++;
      $display("FAIL single_after: got done=%b busy=%b gnt=%b res=%0d expected 0000 0 0000 7", DONE, BUSY, GNT, RES);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    set_op(2, 8'd200, 8'd100);
    REQ = 4'b0100;
    wait_gnt(ok);
    checks++;
    if (!ok || GNT !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_grant: got seen=%b gnt=%b expected 1 0100", ok, GNT);
    end
    wait_done(ok);
    checks++;
    if (!ok || DONE !== 4'b0100 || RES !== 8'd44) begin
      errors++;
      $display("FAIL wrap_done: got seen=%b done=%b res=%0d expected 1 0100 44", ok, DONE, RES);
    end
    REQ = '0;
    @(negedge CLK);
  endtask

  task automatic test_simultaneous;
    bit ok;
    RST = 1'b1;
    set_op(1, 8'd10, 8'd20);
    set_op(3, 8'd50, 8'd60);
    REQ = 4'b1010;
    @(negedge CLK);
    RST = 1'b0;
    wait_gnt(ok);
    checks++;
    if (!ok || GNT !== 4'b0010) begin
      errors++;
      $display("FAIL simul_first_grant: got seen=%b gnt=%b expected 1 0010", ok, GNT);
    end
    wait_done(ok);
    checks++;
    if (!ok || DONE !== 4'b0010 || RES !== 8'd30) begin
      errors++;
      $display("FAIL simul_first_done: got seen=%b done=%b res=%0d expected 1 0010 30", ok, DONE, RES);
    end
    REQ = 4'b1000;
    wait_gnt(ok);
    checks++;
    if (!ok || GNT !== 4'b1000) begin
      errors++;
      $display("FAIL simul_second_grant: got seen=%b gnt=%b expected 1 1000", ok, GNT);
    end
    wait_done(ok);
    checks++;
    if (!ok || DONE !== 4'b1000 || RES !== 8'd110) begin
      errors++;
      $display("FAIL simul_second_done: got seen=%b done=%b res=%0d expected 1 1000 110", ok, DONE, RES);
    end
    REQ = '0;
    @(negedge CLK);
  endtask

  task automatic test_fairness;
    bit ok;
    int order [6]   = '{0, 1, 2, 3, 0, 1};
    int exp_sum [4] = '{3, 14, 25, 36};
    logic [NREQ-1:0] exp_oh;
    // Requester i adds (10*i+1) + (i+2).
    set_op(0, 8'd1, 8'd2);
    set_op(1, 8'd11, 8'd3);
    set_op(2, 8'd21, 8'd4);
    set_op(3, 8'd31, 8'd5);
    REQ = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      exp_oh = '0;
      exp_oh[order[n]] = 1'b1;
      wait_gnt(ok);
      checks++;
      if (!ok || GNT !== exp_oh) begin
        errors++;
        $display("FAIL fair_grant_%0d: got seen=%b gnt=%b expected 1 %b", n, ok, GNT, exp_oh);
      end
      wait_done(ok);
      checks++;
      if (!ok || DONE !== exp_oh || RES !== BITS'(exp_sum[order[n]])) begin
        errors++;
        $display("FAIL fair_done_%0d: got seen=%b done=%b res=%0d expected 1 %b %0d", n, ok, DONE, RES, exp_oh, exp_sum[order[n]]);
      end
    end
    REQ = '0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit done_seen;
    dead = 1'b1;
    set_op(0, 8'd5, 8'd6);
    REQ = 4'b0001;
    wait_ie(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_reach_issue: got iea=%b expected 1", AD_IEA);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (AD_IEA !== 1'b0 || AD_IEB !== 1'b0 || GNT !== 4'b0000 || BUSY !== 1'b0 || DONE !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async: got iea=%b ieb=%b gnt=%b busy=%b done=%b expected 0 0 0000 0 0000", AD_IEA, AD_IEB, GNT, BUSY, DONE);
    end
    done_seen = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (DONE != '0) done_seen = 1'b1;
    end
    dead = 1'b0;
    RST  = 1'b0;
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL rstmid_no_done: got done during reset expected none");
    end
    wait_done(ok);
    checks++;
    if (!ok || DONE !== 4'b0001 || RES !== 8'd11) begin
      errors++;
      $display("FAIL rstmid_resume: got seen=%b done=%b res=%0d expected 1 0001 11", ok, DONE, RES);
    end
    REQ = '0;
    @(negedge CLK);
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL err_idle: got %b expected 0", ERR);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    bit early;
    dead = 1'b1;
    set_op(0, 8'd1, 8'd1);
    REQ = 4'b0001;
    wait_ie(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_reach_issue: got iea=%b expected 1", AD_IEA);
    end
    early = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      if (ERR) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL tmo_early: got err before 16 cycles expected none");
    end
    @(negedge CLK);
    checks++;
    if (ERR !== 1'b1 || AD_IEA !== 1'b0 || AD_IEB !== 1'b0 || DONE !== 4'b0001 || RES !== 8'd11) begin
      errors++;
      $display("FAIL tmo_fire: got err=%b iea=%b ieb=%b done=%b res=%0d expected 1 0 0 0001 11", ERR, AD_IEA, AD_IEB, DONE, RES);
    end
    REQ  = '0;
    dead = 1'b0;
    repeat (5) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL tmo_sticky: got err=%b busy=%b expected 1 0", ERR, BUSY);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got err=%b expected 0", ERR);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_simultaneous;
    test_fairness;
    test_reset_mid;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arb.md
Name: adder_arb

Overview:
Shares one `adder` instance among NREQ requesters using round-robin arbitration. Sequences the adder's level handshake on the granted requester's behalf:
- present operands, then raise IEA/IEB;
- wait for OE, capture Y, then drop IEA/IEB;
- wait for OE to fall.

It returns the captured sum with a one-cycle DONE pulse. It sits between the requesting blocks and the single `adder` datapath.

Parameters:
- BITS, 8, operand/result width; must match the adder's BITS.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, cycles allowed in ISSUE or DRAIN before abort (used only with ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  NREQ  level request per requester; held until its DONE pulse.
- REQ_A  in  NREQ*BITS  packed A operands, slice i = requester i; stable while REQ[i]=1.
- REQ_B  in  NREQ*BITS  packed B operands, same packing.
- GNT  out  NREQ  one-hot grant, registered.
- DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- RES  out  BITS  captured sum; valid in the DONE cycle, held until the next capture.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN.
- AD_A  out  BITS  to adder A.
- AD_B  out  BITS  to adder B.
- AD_IEA  out  1  to adder IEA.
- AD_IEB  out  1  to adder IEB.
- AD_Y  in  BITS  from adder Y.
- AD_OE  in  1  from adder OE.

Behaviour:
- Reset (async, immediate), all outputs as follows:
  - GNT, DONE, RES, BUSY, ERR, AD_A, AD_B, AD_IEA, AD_IEB are 0.
  - State is IDLE.
  - Round-robin pointer is NREQ-1, so requester 0 wins first.
- A reset during a transaction drops IEA/IEB immediately. No DONE is issued; the requester re-arbitrates after reset.
- All outputs are registered. The FSM has six states: IDLE, SETUP, ISSUE, CAPTURE, DRAIN, FIN.
- IDLE:
  - If any REQ is set, grant the first set index after the pointer, cyclically.
  - Set GNT one-hot, load AD_A/AD_B from that requester's slice, pointer := granted index, go to SETUP.
  - If no REQ is set, stay in IDLE.
- SETUP (exactly 1 cycle): operands stable for one full cycle; AD_IEA=AD_IEB=0. Go to ISSUE.
- ISSUE:
  - AD_IEA=AD_IEB=1; AD_A/AD_B are held.
  - Remain while AD_OE=0. When AD_OE is sampled 1, RES := AD_Y and go to CAPTURE.
- CAPTURE (1 cycle): AD_IEA=AD_IEB=0, so both IEs fall together. Go to DRAIN.
- DRAIN: remain while AD_OE=1. When AD_OE is sampled 0, go to FIN.
- FIN (1 cycle): DONE[g]=1. Next state is IDLE with GNT cleared.
- Minimum REQ-to-DONE latency: 4 + (adder OE latency) + (adder OE-fall latency) cycles.
- After FIN, at least one IDLE cycle precedes the next grant.
- Requester rules:
  - A requester that drops REQ mid-transaction does not abort; its transaction completes and DONE still pulses.
  - A requester whose REQ is still high in the IDLE cycle after its DONE is treated as a new request and arbitrated normally.
- Arithmetic: none here. RES is exactly AD_Y (the adder's sum, modulo 2^BITS).
- An AD_OE that is already 1 on entry to ISSUE (adder misbehaving) is accepted as completion.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE and DRAIN, cleared on state entry.
  - Reaching TIMEOUT cycles sets ERR (sticky, cleared only by RST), forces AD_IEA=AD_IEB=0, and goes to FIN.
  - FIN still pulses DONE; RES keeps its previous value.
- Undefined: no counter; ISSUE and DRAIN wait indefinitely; ERR is tied to 0.

Test Plan:
- Single request: BITS=8, REQ=0001, A0=3, B0=4.
  Required: GNT=0001 one cycle later; AD_IEA/AD_IEB rise after the SETUP cycle; DONE=0001 for one cycle with RES=7; BUSY low afterwards.
- Wrap-around: A2=200, B2=100.
  Required: RES=44 and DONE[2] pulses.
- Simultaneous requests: REQ=1010 asserted together out of reset.
  Required: grant order 1 then 3; DONE[1] precedes DONE[3]; RES equals each requester's sum at its own DONE.
- Fairness: REQ=1111 held continuously.
  Required: grant sequence 0,1,2,3,0,1; no requester is granted twice before the others are served.
- Reset mid-ISSUE: assert RST while AD_IEA=1.
  Required: AD_IEA, AD_IEB, GNT and BUSY go to 0 without waiting for a clock edge; no DONE; after release, REQ=0001 is served normally.
- ARB_TIMEOUT_EN with TIMEOUT=16 and the bench adder never raising OE.
  Required: ERR=1 exactly 16 cycles after ISSUE entry; IEs dropped; DONE pulses; ERR stays 1 until RST.
